// File: rtl/ejer2_cpu_div_pkg.sv
// Shared definitions for the ejer2 CPU divide cell.
//   DIV_DATA_W    : default operand/result width
//   DIV_MAX_W     : widest DATA_W the all-ones constant below can serve
//   DIV_ZERO_QUOT : quotient returned on divide-by-zero (all ones)
//   div_state_t   : divider FSM states with fixed legacy encodings
package ejer2_cpu_div_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_MAX_W  = 64;

  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/ejer2_cpu_div_step.sv
// One restoring-division iteration (combinational).
//   rem      : current partial remainder (always < divisor when divisor != 0)
//   dvd_msb  : dividend bit shifted into the remainder this iteration
//   divisor  : magnitude of the divisor
//   next_rem : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this iteration
module ejer2_cpu_div_step
  import ejer2_cpu_div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic              q_bit
);

  logic [DATA_W:0] rem_shifted;
  logic [DATA_W:0] trial;

  // rem < divisor keeps rem_shifted < 2*divisor, so one extra bit is enough
  // for the trial difference to carry its sign in the MSB.
  always_comb begin
    rem_shifted = {rem, dvd_msb};
    trial       = rem_shifted - {1'b0, divisor};
    q_bit       = ~trial[DATA_W];
    next_rem    = q_bit ? trial[DATA_W-1:0] : rem_shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/ejer2_cpu_div_cell.sv
// Iterative radix-2 restoring divider serving div/divu. Fixed latency:
// start accepted at edge t0 gives done during cycle t0+DATA_W+1.
//   clk, reset_n        : clock (rising edge), async active-low reset
//   M_div_src1/src2     : dividend / divisor, sampled when start is accepted
//   M_div_signed        : 1 = two's-complement, 0 = unsigned
//   M_div_start         : start request, honoured only in IDLE
//   M_div_busy          : high in CALC and FIX
//   M_div_done          : one-cycle pulse when results are registered
//   M_div_quotient/remainder/by_zero : results, held until next accepted start
module ejer2_cpu_div_cell
  import ejer2_cpu_div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] M_div_src1,
  input  logic [DATA_W-1:0] M_div_src2,
  input  logic              M_div_signed,
  input  logic              M_div_start,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quotient,
  output logic [DATA_W-1:0] M_div_remainder,
  output logic              M_div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] src1_q;
  logic              sign_q;
  logic              sign_r;
  logic              zero_q;

  logic [DATA_W-1:0] abs_src1;
  logic [DATA_W-1:0] abs_src2;
  logic [DATA_W-1:0] next_rem;
  logic              q_bit;

  // Negating the most negative value wraps to itself, which is exactly its
  // unsigned magnitude, so no special case is needed.
  always_comb begin
    abs_src1 = (M_div_signed && M_div_src1[DATA_W-1]) ? -M_div_src1 : M_div_src1;
    abs_src2 = (M_div_signed && M_div_src2[DATA_W-1]) ? -M_div_src2 : M_div_src2;
  end

  ejer2_cpu_div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[DATA_W-1]),
    .divisor  (dvs_q),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  assign M_div_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rem_q           <= '0;
      dvd_q           <= '0;
      dvs_q           <= '0;
      src1_q          <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      zero_q          <= 1'b0;
      M_div_done      <= 1'b0;
      M_div_quotient  <= '0;
      M_div_remainder <= '0;
      M_div_by_zero   <= 1'b0;
    end else begin
      M_div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (M_div_start) begin
            dvd_q           <= abs_src1;
            dvs_q           <= abs_src2;
            src1_q          <= M_div_src1;
            sign_q          <= M_div_signed & (M_div_src1[DATA_W-1] ^ M_div_src2[DATA_W-1]);
            sign_r          <= M_div_signed & M_div_src1[DATA_W-1];
            zero_q          <= (M_div_src2 == '0);
            rem_q           <= '0;
            cnt             <= '0;
            M_div_quotient  <= '0;
            M_div_remainder <= '0;
            M_div_by_zero   <= 1'b0;
            state           <= CALC;
          end
        end
        CALC: begin
          // Quotient bits fill dvd_q from the bottom as dividend bits leave the top.
          rem_q <= next_rem;
          dvd_q <= {dvd_q[DATA_W-2:0], q_bit};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero_q) begin
            M_div_quotient  <= DIV_ZERO_QUOT[DATA_W-1:0];
            M_div_remainder <= src1_q;
            M_div_by_zero   <= 1'b1;
          end else begin
            M_div_quotient  <= sign_q ? -dvd_q : dvd_q;
            M_div_remainder <= sign_r ? -rem_q : rem_q;
            M_div_by_zero   <= 1'b0;
          end
          M_div_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ejer2_cpu_div_cell.sv
module tb_ejer2_cpu_div_cell;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LATENCY = DATA_W + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        sgn = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        by_zero;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cycle = 0;
  exp_t        sb[$];

  ejer2_cpu_div_cell #(
    .DATA_W(DATA_W),
    .CNT_W (6)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .M_div_src1      (src1),
    .M_div_src2      (src2),
    .M_div_signed    (sgn),
    .M_div_start     (start),
    .M_div_busy      (busy),
    .M_div_done      (done),
    .M_div_quotient  (quotient),
    .M_div_remainder (remainder),
    .M_div_by_zero   (by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division via native SV arithmetic.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic bz);
    int sa;
    int sb_v;
    bz = (b == 32'h0);
    if (bz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        sa   = a;
        sb_v = b;
        q    = sa / sb_v;
        r    = sa % sb_v;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Output monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_eq("quotient", quotient, e.q);
        check_eq("remainder", remainder, e.r);
        check_eq("by_zero", by_zero, e.bz);
        check_eq("done_cycle", cycle, e.due);
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic ebz);
    int unsigned busy_n = 0;
    logic        seen = 1'b0;
    @(negedge clk);
    src1  = a;
    src2  = b;
    sgn   = s;
    start = 1'b1;
    sb.push_back('{eq, er, ebz, cycle + 1 + LATENCY});
    @(negedge clk);
    start = 1'b0;
    src1  = $urandom;
    src2  = $urandom;
    sgn   = ~s;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
    check_eq("done_seen", seen, 1'b1);
    check_eq("busy_len", busy_n, LATENCY);
    check_eq("busy_at_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("hold_q", quotient, eq);
    check_eq("hold_r", remainder, er);
    check_eq("hold_bz", by_zero, ebz);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] a, b, q, r;
    logic        s, bz;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_q", quotient, 32'h0);
    check_eq("rst_r", remainder, 32'h0);
    check_eq("rst_bz", by_zero, 1'b0);
    reset_n = 1'b1;

    do_op(32'd100,        32'd7,        1'b0, 32'd14,         32'd2,        1'b0);
    do_op(32'hFFFF_FFF9,  32'd2,        1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0);
    do_op(32'd7,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,        1'b0);
    do_op(32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0,        1'b0);
    do_op(32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 32'h0,         32'h8000_0000, 1'b0);
    do_op(32'h1234,       32'h0,        1'b0, 32'hFFFF_FFFF,  32'h1234,     1'b1);
    do_op(32'h1234,       32'h0,        1'b1, 32'hFFFF_FFFF,  32'h1234,     1'b1);
    do_op(32'hFFFF_FFFF,  32'h1,        1'b0, 32'hFFFF_FFFF,  32'h0,        1'b0);

    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      b = $urandom_range(1, 100000);
      if ($urandom_range(0, 1) == 1) b = -b;
      s = k[0];
      ref_div(a, b, s, q, r, bz);
      do_op(a, b, s, q, r, bz);
    end

    // Start held high with operands changing every cycle: only the operands
    // present in IDLE cycles may be used.
    @(negedge clk);
    for (int i = 0; i < 3 * 34; i++) begin
      a = $urandom;
      b = $urandom_range(1, 5000);
      if ($urandom_range(0, 1) == 1) b = -b;
      s = $urandom_range(0, 1);
      src1  = a;
      src2  = b;
      sgn   = s;
      start = 1'b1;
      if (i % 34 == 0) begin
        ref_div(a, b, s, q, r, bz);
        sb.push_back('{q, r, bz, cycle + 1 + LATENCY});
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("b2b_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of an operation aborts it without a done.
    src1  = 32'd1000;
    src2  = 32'd3;
    sgn   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_q", quotient, 32'h0);
    check_eq("arst_r", remainder, 32'h0);
    check_eq("arst_bz", by_zero, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    repeat (5) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
